ex_stage_mc: RTL and testbench
==============================

# ex_stage_mc

Parametrised execute stage with an iterative multiply/divide unit and internal EX/MEM register. Sits between the ID/EX register and the memory stage. It computes the ALU result, the branch target and the destination register, and runs MULT/MULTU/DIV/DIVU into internal HI/LO registers. It raises a stall toward the hazard unit only when an instruction depends on an unfinished HI/LO result.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be ≥8 and even.
- REGW, 5, register-address width.
- CTRW, 5, width of pass-through control bits forwarded to MEM/WB.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the clock edge.
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble).
- ctrl_regdst  in  1  1 selects rd_addr as destination, 0 selects rt_addr.
- ctrl_aluop  in  2  00 add, 01 sub, 10 funct-decoded, 11 reserved (result 0).
- ctrl_alusrc  in  1  1 selects imm as ALU operand B, 0 selects rt_data.
- ctrl_pass  in  CTRW  forwarded unchanged to ctrl_out.
- npc  in  WIDTH  PC+4 of the instruction.
- rs_data, rt_data  in  WIDTH  register operands.
- imm  in  WIDTH  sign-extended immediate; imm[5:0] is funct.
- rt_addr, rd_addr  in  REGW  candidate destinations.
- ex_stall  out  1  combinational; upstream must hold ID/EX and PC while high.
- md_busy  out  1  multiply/divide iteration in progress.
- out_valid  out  1  EX/MEM holds a real instruction.
- ctrl_out  out  CTRW  registered ctrl_pass.
- branch_target  out  WIDTH  registered npc + (imm << 2).
- zero  out  1  registered (alu_result == 0).
- alu_result, rt_data_out  out  WIDTH  registered result and registered rt_data.
- dest_addr  out  REGW  registered destination.

## Operation
- Funct decode (aluop 10): 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0), 0x10 mfhi, 0x12 mflo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu. Any other funct gives result 0.
- Arithmetic is modulo 2^WIDTH; no overflow traps. branch_target wraps modulo 2^WIDTH.
- Mul/div ops:
  - Start the unit when in_valid && !ex_stall.
  - The instruction itself passes to EX/MEM with alu_result 0; decode has already cleared its regwrite in ctrl_pass.
- Multiply: shift-add over WIDTH iterations.
  - Full 2·WIDTH product: HI = upper half, LO = lower half.
  - Signed multiply runs on magnitudes, then negates the product if the operand signs differ.
- Divide: restoring divide over WIDTH iterations on magnitudes; LO = quotient, HI = remainder.
  - Signed divide: quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = dividend (the unsigned magnitude result, sign-fixed as above).
  - Signed most-negative / −1: LO = most-negative, HI = 0.
- Interlock: ex_stall = in_valid && md_busy && (instruction is mfhi, mflo, or any mul/div op). All other instructions proceed while the unit runs.
- While ex_stall is high, EX/MEM loads a bubble: out_valid = 0, ctrl_out = 0, all other outputs 0.
- A bubble input (in_valid = 0) also loads a bubble and never starts the unit.

## Timing
- EX/MEM latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Mul/div accepted at edge N:
  - md_busy is high for cycles N+1 … N+WIDTH.
  - HI/LO are written at the edge ending cycle N+WIDTH; md_busy is low from cycle N+WIDTH+1.
- An mfhi presented during cycle N+WIDTH stalls. Presented in cycle N+WIDTH+1, it proceeds and reads the new HI.
- mfhi/mflo with the unit idle read HI/LO combinationally in the same cycle.
- Reset (reset == 0 at an edge):
  - All outputs become 0, including out_valid, zero, md_busy and ex_stall (ex_stall because md_busy clears).
  - HI, LO and the iteration counter become 0.
  - An operation in flight is abandoned with no HI/LO update.
- Reset takes priority over every other event at the same edge.

## Structure
- Package ex_pkg holds:
  - funct constants;
  - aluop encodings;
  - function is_muldiv(funct) and function is_hilo_read(funct).
- Sub-module ex_muldiv, parametrised by WIDTH, holds the iterative unit and HI/LO:
  - inputs: start, op[1:0], a, b;
  - outputs: busy, hi, lo;
  - uses a log2(WIDTH)+1-bit counter.
- ex_stage_mc holds the decode, ALU, destination mux, target adder, interlock and EX/MEM register.

## Test plan
- Reset: drive reset = 0 with random inputs for 3 cycles → every output is 0; release → the first valid add appears one cycle later.
- ALU and target: add 7 + (−3), then slt −1 < 1 with npc = 0x100, imm = 4 →
  - add: alu_result 4, zero 0;
  - slt: alu_result 1;
  - branch_target 0x110.
- Signed multiply: mult 0xFFFFFFFE × 3, then mflo next cycle →
  - mflo stalls 32 cycles;
  - alu_result 0xFFFFFFFA after mflo;
  - mfhi gives 0xFFFFFFFF;
  - an independent add issued during md_busy is not stalled.
- Divide corners: divu 7/0 → LO 0xFFFFFFFF, HI 7; div 0x80000000/−1 → LO 0x80000000, HI 0; div −7/2 → LO −3, HI −1.
- Abort: reset asserted 10 cycles into a div → md_busy 0, HI = LO = 0; the next mfhi returns 0 without a stall.
- WIDTH = 8 instance: multu 0xFF × 0xFF → HI 0xFE, LO 0x01; md_busy high for exactly 8 cycles.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op select, funct codes and
// mul/div classification helpers.
package ex_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_RSVD  = 2'b11
  } aluop_e;

  // Order matches funct[1:0] of MULT/MULTU/DIV/DIVU
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic logic is_hilo_read(input logic [5:0] funct);
    return funct inside {F_MFHI, F_MFLO};
  endfunction

endpackage

// File: rtl/ex_stage_mc_muldiv.sv
// Iterative multiply (shift-add) / divide (restoring) unit with HI/LO.
// Operates on magnitudes; sign fix-up is folded into the final iteration.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]        cnt;
  md_op_e               op_q;
  logic                 neg_q, neg_r, is_signed, is_div;
  logic [2*WIDTH-1:0]   mcand, prod, prod_n, prod_fix;
  logic [WIDTH-1:0]     mplier, quo, quo_n, dvsr, q_fix, r_fix, mag_a, mag_b;
  logic [WIDTH:0]       rem, rem_sh, diff, rem_n;

  always_comb begin
    is_signed = (md_op_e'(op) == MD_MULT) || (md_op_e'(op) == MD_DIV);
    is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    prod_n    = prod + (mplier[0] ? mcand : '0);
    prod_fix  = neg_q ? -prod_n : prod_n;
    // rem < divisor before the shift, so diff never exceeds WIDTH bits;
    // a zero divisor keeps subtracting 0, giving all-ones / dividend.
    rem_sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvsr};
    rem_n     = diff[WIDTH] ? rem_sh : diff;
    quo_n     = {quo[WIDTH-2:0], ~diff[WIDTH]};
    q_fix     = neg_q ? -quo_n : quo_n;
    r_fix     = neg_r ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
  end

  assign busy = (cnt != '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      op_q   <= MD_MULT;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
    end else if (start && !busy) begin
      cnt    <= CW'(WIDTH);
      op_q   <= md_op_e'(op);
      neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= is_signed && a[WIDTH-1];
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      prod   <= '0;
      rem    <= '0;
      quo    <= mag_a;
      dvsr   <= mag_b;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (is_div) begin
        rem <= rem_n;
        quo <= quo_n;
      end else begin
        prod   <= prod_n;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (cnt == CW'(1)) begin
        if (is_div) begin
          lo <= q_fix;
          hi <= r_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: ALU, branch target, destination mux, HI/LO interlock and
// the EX/MEM pipeline register.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5,
  parameter int CTRW  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             ctrl_regdst,
  input  logic [1:0]       ctrl_aluop,
  input  logic             ctrl_alusrc,
  input  logic [CTRW-1:0]  ctrl_pass,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [REGW-1:0]  rt_addr,
  input  logic [REGW-1:0]  rd_addr,
  output logic             ex_stall,
  output logic             md_busy,
  output logic             out_valid,
  output logic [CTRW-1:0]  ctrl_out,
  output logic [WIDTH-1:0] branch_target,
  output logic             zero,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] rt_data_out,
  output logic [REGW-1:0]  dest_addr
);

  aluop_e           aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_b, alu_y, br_t, hi, lo;
  logic             is_fn, md_op, hilo_rd, md_start, load;

  always_comb begin
    aluop   = aluop_e'(ctrl_aluop);
    funct   = imm[5:0];
    op_b    = ctrl_alusrc ? imm : rt_data;
    is_fn   = (aluop == ALU_FUNCT);
    md_op   = is_fn && is_muldiv(funct);
    hilo_rd = is_fn && is_hilo_read(funct);
    br_t    = npc + (imm << 2);
    alu_y   = '0;
    unique case (aluop)
      ALU_ADD:   alu_y = rs_data + op_b;
      ALU_SUB:   alu_y = rs_data - op_b;
      ALU_FUNCT: begin
        case (funct)
          F_ADD:   alu_y = rs_data + op_b;
          F_SUB:   alu_y = rs_data - op_b;
          F_AND:   alu_y = rs_data & op_b;
          F_OR:    alu_y = rs_data | op_b;
          F_SLT:   alu_y = {{(WIDTH-1){1'b0}}, $signed(rs_data) < $signed(op_b)};
          F_MFHI:  alu_y = hi;
          F_MFLO:  alu_y = lo;
          default: alu_y = '0;
        endcase
      end
      ALU_RSVD:  alu_y = '0;
    endcase
  end

  assign ex_stall = in_valid && md_busy && (md_op || hilo_rd);
  assign md_start = in_valid && !ex_stall && md_op;
  assign load     = in_valid && !ex_stall;

  ex_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock (clock),
    .reset (reset),
    .start (md_start),
    .op    (funct[1:0]),
    .a     (rs_data),
    .b     (rt_data),
    .busy  (md_busy),
    .hi    (hi),
    .lo    (lo)
  );

  always_ff @(posedge clock) begin
    if (!reset || !load) begin
      out_valid     <= 1'b0;
      ctrl_out      <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      alu_result    <= '0;
      rt_data_out   <= '0;
      dest_addr     <= '0;
    end else begin
      out_valid     <= 1'b1;
      ctrl_out      <= ctrl_pass;
      branch_target <= br_t;
      zero          <= (alu_y == '0);
      alu_result    <= alu_y;
      rt_data_out   <= rt_data;
      dest_addr     <= ctrl_regdst ? rd_addr : rt_addr;
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: randomized ALU/mul/div traffic against
// an arithmetic reference model, plus directed interlock, corner and abort cases.
module tb_ex_stage_mc;

  localparam logic [5:0] T_ADD = 6'h20, T_SUB = 6'h22, T_AND = 6'h24, T_OR = 6'h25;
  localparam logic [5:0] T_SLT = 6'h2A, T_MFHI = 6'h10, T_MFLO = 6'h12;
  localparam logic [5:0] T_MULT = 6'h18, T_MULTU = 6'h19, T_DIV = 6'h1A, T_DIVU = 6'h1B;

  logic        clock, reset, in_valid, ctrl_regdst, ctrl_alusrc;
  logic [1:0]  ctrl_aluop;
  logic [4:0]  ctrl_pass, rt_addr, rd_addr, ctrl_out, dest_addr;
  logic [31:0] npc, rs_data, rt_data, imm, branch_target, alu_result, rt_data_out;
  logic        ex_stall, md_busy, out_valid, zero;

  logic        w8_reset, w8_in_valid, w8_regdst, w8_alusrc;
  logic [1:0]  w8_aluop;
  logic [4:0]  w8_pass, w8_rt_addr, w8_rd_addr, w8_ctrl_out, w8_dest;
  logic [7:0]  w8_npc, w8_rs, w8_rt, w8_imm, w8_target, w8_result, w8_rt_out;
  logic        w8_stall, w8_busy, w8_valid, w8_zero;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  ex_stage_mc dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .ctrl_regdst(ctrl_regdst),
    .ctrl_aluop(ctrl_aluop), .ctrl_alusrc(ctrl_alusrc), .ctrl_pass(ctrl_pass),
    .npc(npc), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .ex_stall(ex_stall), .md_busy(md_busy),
    .out_valid(out_valid), .ctrl_out(ctrl_out), .branch_target(branch_target),
    .zero(zero), .alu_result(alu_result), .rt_data_out(rt_data_out), .dest_addr(dest_addr)
  );

  ex_stage_mc #(.WIDTH(8), .REGW(5), .CTRW(5)) dut8 (
    .clock(clock), .reset(w8_reset), .in_valid(w8_in_valid), .ctrl_regdst(w8_regdst),
    .ctrl_aluop(w8_aluop), .ctrl_alusrc(w8_alusrc), .ctrl_pass(w8_pass),
    .npc(w8_npc), .rs_data(w8_rs), .rt_data(w8_rt), .imm(w8_imm),
    .rt_addr(w8_rt_addr), .rd_addr(w8_rd_addr), .ex_stall(w8_stall), .md_busy(w8_busy),
    .out_valid(w8_valid), .ctrl_out(w8_ctrl_out), .branch_target(w8_target),
    .zero(w8_zero), .alu_result(w8_result), .rt_data_out(w8_rt_out), .dest_addr(w8_dest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_bubble();
    in_valid    = 1'b0;
    ctrl_regdst = 1'($urandom());
    ctrl_aluop  = 2'($urandom());
    ctrl_alusrc = 1'($urandom());
    ctrl_pass   = 5'($urandom());
    npc         = $urandom();
    rs_data     = $urandom();
    rt_data     = $urandom();
    imm         = $urandom();
    rt_addr     = 5'($urandom());
    rd_addr     = 5'($urandom());
  endtask

  task automatic set_rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = $urandom();
    in_valid    = 1'b1;
    ctrl_aluop  = 2'b10;
    ctrl_alusrc = 1'b0;
    ctrl_regdst = 1'b1;
    imm         = {r[31:6], f};
    rs_data     = a;
    rt_data     = b;
    npc         = $urandom();
    ctrl_pass   = 5'($urandom());
    rt_addr     = 5'($urandom());
    rd_addr     = 5'($urandom());
  endtask

  // Reference EX/MEM contents for the instruction currently on the inputs
  function automatic logic [107:0] exp_bus();
    logic [31:0] b, r;
    if (!in_valid) return '0;
    b = ctrl_alusrc ? imm : rt_data;
    r = 32'd0;
    case (ctrl_aluop)
      2'd0: r = rs_data + b;
      2'd1: r = rs_data - b;
      2'd2: begin
        if (imm[5:0] == T_ADD)       r = rs_data + b;
        else if (imm[5:0] == T_SUB)  r = rs_data - b;
        else if (imm[5:0] == T_AND)  r = rs_data & b;
        else if (imm[5:0] == T_OR)   r = rs_data | b;
        else if (imm[5:0] == T_SLT)  r = ($signed(rs_data) < $signed(b)) ? 32'd1 : 32'd0;
        else if (imm[5:0] == T_MFHI) r = m_hi;
        else if (imm[5:0] == T_MFLO) r = m_lo;
      end
      default: r = 32'd0;
    endcase
    return {1'b1, ctrl_pass, npc + imm * 32'd4, (r == 32'd0), r, rt_data,
            ctrl_regdst ? rd_addr : rt_addr};
  endfunction

  function automatic logic [107:0] act_bus();
    return {out_valid, ctrl_out, branch_target, zero, alu_result, rt_data_out, dest_addr};
  endfunction

  function automatic void md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    longint p;
    logic [63:0] u;
    hi = '0;
    lo = '0;
    if (f == T_MULT) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      hi = p[63:32];
      lo = p[31:0];
    end else if (f == T_MULTU) begin
      u  = {32'd0, a} * {32'd0, b};
      hi = u[63:32];
      lo = u[31:0];
    end else if (f == T_DIV) begin
      if (b == 32'd0) begin
        hi = a;
        lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = a;
        hi = 32'd0;
      end else begin
        lo = $signed(a) / $signed(b);
        hi = $signed(a) % $signed(b);
      end
    end else begin
      if (b == 32'd0) begin
        hi = a;
        lo = 32'hFFFF_FFFF;
      end else begin
        lo = a / b;
        hi = a % b;
      end
    end
  endfunction

  // Issues one mul/div, waits it out, then reads HI and LO through mfhi/mflo
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int busy_n);
    set_rtype(f, a, b);
    tick();
    set_bubble();
    busy_n = 0;
    while (md_busy && busy_n < 200) begin
      busy_n++;
      tick();
    end
    checks++;
    if (busy_n >= 200) begin
      failures++;
      $display("FAIL md_timeout busy_cycles=%0d required<200", busy_n);
    end
    md_model(f, a, b, m_hi, m_lo);
    set_rtype(T_MFHI, $urandom(), $urandom());
    tick();
    hi = alu_result;
    set_rtype(T_MFLO, $urandom(), $urandom());
    tick();
    lo = alu_result;
    set_bubble();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rtype(T_ADD, $urandom(), $urandom());
      tick();
      checks++;
      if ({act_bus(), md_busy, ex_stall} !== 110'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%h required=0", i, {act_bus(), md_busy, ex_stall});
      end
    end
    m_hi = '0;
    m_lo = '0;
    reset = 1'b1;
    set_rtype(T_ADD, $urandom(), $urandom());
    begin
      logic [107:0] e;
      e = exp_bus();
      tick();
      checks++;
      if (act_bus() !== e) begin
        failures++;
        $display("FAIL reset_release_add got=%h required=%h", act_bus(), e);
      end
    end
  endtask

  task automatic test_alu_target();
    set_rtype(T_ADD, 32'd7, 32'd0);
    ctrl_aluop  = 2'b00;
    ctrl_alusrc = 1'b1;
    imm         = 32'hFFFF_FFFD;
    tick();
    checks++;
    if (alu_result !== 32'd4 || zero !== 1'b0) begin
      failures++;
      $display("FAIL add_7_m3 got=%h zero=%b required=4 zero=0", alu_result, zero);
    end
    set_rtype(T_SLT, 32'hFFFF_FFFF, 32'd1);
    tick();
    checks++;
    if (alu_result !== 32'd1) begin
      failures++;
      $display("FAIL slt_m1_1 got=%h required=1", alu_result);
    end
    set_rtype(T_ADD, 32'd5, 32'd5);
    ctrl_aluop = 2'b01;
    npc = 32'h100;
    imm = 32'd4;
    ctrl_alusrc = 1'b0;
    tick();
    checks++;
    if (branch_target !== 32'h110 || zero !== 1'b1) begin
      failures++;
      $display("FAIL target_100_4 got=%h zero=%b required=110 zero=1", branch_target, zero);
    end
    set_bubble();
  endtask

  task automatic test_mult_interlock();
    int stall_n;
    logic [107:0] e;
    set_rtype(T_MULT, 32'hFFFF_FFFE, 32'd3);
    tick();
    md_model(T_MULT, 32'hFFFF_FFFE, 32'd3, m_hi, m_lo);
    set_rtype(T_MFLO, $urandom(), $urandom());
    stall_n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!ex_stall) break;
      stall_n++;
      tick();
      if (stall_n == 1) begin
        checks++;
        if (act_bus() !== 108'd0) begin
          failures++;
          $display("FAIL stall_bubble got=%h required=0", act_bus());
        end
      end
    end
    tick();
    checks++;
    if (stall_n !== 32) begin
      failures++;
      $display("FAIL mflo_stall_cycles got=%0d required=32", stall_n);
    end
    checks++;
    if (alu_result !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL mult_lo got=%h required=fffffffa", alu_result);
    end
    set_rtype(T_MFHI, $urandom(), $urandom());
    #1;
    checks++;
    if (ex_stall !== 1'b0) begin
      failures++;
      $display("FAIL mfhi_idle_stall got=%b required=0", ex_stall);
    end
    tick();
    checks++;
    if (alu_result !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL mult_hi got=%h required=ffffffff", alu_result);
    end
    // Independent add while the unit iterates
    set_rtype(T_MULTU, $urandom(), $urandom());
    md_model(T_MULTU, rs_data, rt_data, m_hi, m_lo);
    tick();
    set_rtype(T_ADD, $urandom(), $urandom());
    e = exp_bus();
    #1;
    checks++;
    if (ex_stall !== 1'b0 || md_busy !== 1'b1) begin
      failures++;
      $display("FAIL add_during_busy stall=%b busy=%b required stall=0 busy=1", ex_stall, md_busy);
    end
    tick();
    checks++;
    if (act_bus() !== e) begin
      failures++;
      $display("FAIL add_during_busy_result got=%h required=%h", act_bus(), e);
    end
    set_bubble();
    for (int i = 0; i < 40 && md_busy; i++) tick();
  endtask

  task automatic test_div_corners();
    logic [31:0] hi, lo;
    int bn;
    run_md(T_DIVU, 32'd7, 32'd0, hi, lo, bn);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
      failures++;
      $display("FAIL divu_by_zero got hi=%h lo=%h required hi=7 lo=ffffffff", hi, lo);
    end
    run_md(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, bn);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      failures++;
      $display("FAIL div_minneg_m1 got hi=%h lo=%h required hi=0 lo=80000000", hi, lo);
    end
    run_md(T_DIV, 32'hFFFF_FFF9, 32'd2, hi, lo, bn);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_m7_2 got hi=%h lo=%h required hi=ffffffff lo=fffffffd", hi, lo);
    end
  endtask

  task automatic test_random_md();
    logic [31:0] a, b, hi, lo, ehi, elo;
    logic [5:0] f;
    int bn;
    for (int i = 0; i < 12; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = $urandom();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(4, 28);
      md_model(f, a, b, ehi, elo);
      run_md(f, a, b, hi, lo, bn);
      checks++;
      if (hi !== ehi || lo !== elo || bn !== 32) begin
        failures++;
        $display("FAIL md_random f=%h a=%h b=%h got hi=%h lo=%h busy=%0d required hi=%h lo=%h busy=32",
                 f, a, b, hi, lo, bn, ehi, elo);
      end
    end
  endtask

  task automatic test_random_alu();
    logic [107:0] e;
    logic [5:0] f;
    int k;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        set_bubble();
      end else begin
        k = $urandom_range(0, 3);
        case ($urandom_range(0, 7))
          0: f = T_ADD;
          1: f = T_SUB;
          2: f = T_AND;
          3: f = T_OR;
          4: f = T_SLT;
          5: f = T_MFHI;
          6: f = T_MFLO;
          default: f = 6'($urandom_range(0, 63));
        endcase
        if (f >= 6'h18 && f <= 6'h1B) f = 6'h3F;
        set_rtype(f, $urandom(), $urandom());
        ctrl_aluop  = 2'(k);
        ctrl_alusrc = 1'($urandom());
        ctrl_regdst = 1'($urandom());
        if (k != 2) imm = $urandom();
        if ($urandom_range(0, 3) == 0) rs_data = ctrl_alusrc ? imm : rt_data;
      end
      e = exp_bus();
      tick();
      checks++;
      if (act_bus() !== e) begin
        failures++;
        $display("FAIL alu_random i=%0d aluop=%0d funct=%h got=%h required=%h",
                 i, ctrl_aluop, imm[5:0], act_bus(), e);
      end
    end
    set_bubble();
  endtask

  task automatic test_abort();
    set_rtype(T_DIV, $urandom(), $urandom() | 32'd1);
    tick();
    set_bubble();
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (md_busy !== 1'b0 || ex_stall !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy got busy=%b stall=%b required 0", md_busy, ex_stall);
    end
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    for (int i = 0; i < 40; i++) tick();
    set_rtype(T_MFHI, $urandom(), $urandom());
    #1;
    checks++;
    if (ex_stall !== 1'b0) begin
      failures++;
      $display("FAIL abort_mfhi_stall got=%b required=0", ex_stall);
    end
    tick();
    checks++;
    if (alu_result !== 32'd0) begin
      failures++;
      $display("FAIL abort_hi got=%h required=0", alu_result);
    end
    set_rtype(T_MFLO, $urandom(), $urandom());
    tick();
    checks++;
    if (alu_result !== 32'd0) begin
      failures++;
      $display("FAIL abort_lo got=%h required=0", alu_result);
    end
    set_bubble();
  endtask

  task automatic test_width8();
    int bn;
    w8_reset = 1'b0;
    tick();
    w8_reset    = 1'b1;
    w8_in_valid = 1'b1;
    w8_aluop    = 2'b10;
    w8_alusrc   = 1'b0;
    w8_rs       = 8'hFF;
    w8_rt       = 8'hFF;
    w8_imm      = {2'b00, T_MULTU};
    tick();
    w8_in_valid = 1'b0;
    bn = 0;
    while (w8_busy && bn < 50) begin
      bn++;
      tick();
    end
    checks++;
    if (bn !== 8) begin
      failures++;
      $display("FAIL w8_busy_cycles got=%0d required=8", bn);
    end
    w8_in_valid = 1'b1;
    w8_imm = {2'b00, T_MFHI};
    tick();
    checks++;
    if (w8_result !== 8'hFE) begin
      failures++;
      $display("FAIL w8_hi got=%h required=fe", w8_result);
    end
    w8_imm = {2'b00, T_MFLO};
    tick();
    checks++;
    if (w8_result !== 8'h01) begin
      failures++;
      $display("FAIL w8_lo got=%h required=01", w8_result);
    end
    w8_in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    set_bubble();
    w8_reset = 1'b0; w8_in_valid = 1'b0; w8_regdst = 1'b0; w8_alusrc = 1'b0;
    w8_aluop = 2'b00; w8_pass = '0; w8_rt_addr = '0; w8_rd_addr = '0;
    w8_npc = '0; w8_rs = '0; w8_rt = '0; w8_imm = '0;
    test_reset();
    test_alu_target();
    test_mult_interlock();
    test_div_corners();
    test_random_md();
    test_random_alu();
    test_abort();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
